// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: runs one charge-balance ADC conversion around the
// pulse counters. It clears the counters, waits out the settling windows,
// takes a baseline snapshot, integrates for num_windows 5 ms windows and
// then publishes the signed difference through a valid/ack handshake.
// The final counter values (p1/m1) are taken straight from count_p/count_m
// on the closing tick. The difference is registered on that same edge, so
// result_valid rises one cycle after the last integrating tick.
module adc_conv_sequencer #(
  parameter int CNT_W          = 24,
  parameter int WIN_W          = 8,
  parameter int SETTLE_WINDOWS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [WIN_W-1:0] num_windows,
  input  logic             window_tick,
  input  logic [CNT_W-1:0] count_p,
  input  logic [CNT_W-1:0] count_m,
  output logic             cnt_clear,
  output logic             cnt_en,
  output logic             busy,
  output logic [CNT_W:0]   result,
  output logic             result_valid,
  output logic             overrun,
  input  logic             rd_ack,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_SETTLE    = 3'd2,
    S_INTEGRATE = 3'd3,
    S_COMPUTE   = 3'd4
  } state_t;

  // Tick count that ends the settling phase, widened by one bit so that the
  // incremented window count can be compared without wrapping.
  localparam logic [WIN_W:0] SETTLE_TGT = (WIN_W+1)'(SETTLE_WINDOWS);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]   nwin_q, nwin_d;
  logic [CNT_W-1:0]   p0_q, p0_d;
  logic [CNT_W-1:0]   m0_q, m0_d;
  logic [CNT_W:0]     result_q, result_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               new_result;
  logic [WIN_W:0]     win_inc;
  logic [WIN_W-1:0]   win_sat;
  logic [CNT_W-1:0]   dp, dm;
  logic [CNT_W:0]     diff;

  // Window count after the current tick; the stored counter saturates.
  assign win_inc = {1'b0, win_cnt_q} + 1'b1;
  assign win_sat = (&win_cnt_q) ? win_cnt_q : win_cnt_q + 1'b1;

  // Deltas are taken modulo 2^CNT_W so a counter wrap during integration
  // still yields the true pulse count.
  assign dp   = count_p - p0_q;
  assign dm   = count_m - m0_q;
  assign diff = {1'b0, dp} - {1'b0, dm};

  // Next-state logic: sequencing, window counting and baseline capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned -- an unassigned path would infer a latch.
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    nwin_d     = nwin_q;
    p0_d       = p0_q;
    m0_d       = m0_q;
    new_result = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        win_cnt_d = '0;
        if (start) begin
          nwin_d  = (num_windows == '0) ? WIN_W'(1) : num_windows;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        win_cnt_d = '0;
        state_d   = stop ? S_IDLE : S_SETTLE;
      end

      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (window_tick) begin
          if (win_inc == SETTLE_TGT) begin
            p0_d      = count_p;
            m0_d      = count_m;
            win_cnt_d = '0;
            state_d   = S_INTEGRATE;
          end else begin
            win_cnt_d = win_sat;
          end
        end
      end

      S_INTEGRATE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (window_tick) begin
          if (win_inc == {1'b0, nwin_q}) begin
            new_result = 1'b1;
            win_cnt_d  = '0;
            state_d    = S_COMPUTE;
          end else begin
            win_cnt_d = win_sat;
          end
        end
      end

      S_COMPUTE: begin
        state_d = (!stop && cont) ? S_CLEAR : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Readout side: publish new results, track overrun, honour rd_ack.
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (new_result) begin
      result_d  = diff;
      valid_d   = 1'b1;
      // An ack in the same cycle consumes the old result, so nothing is lost.
      overrun_d = valid_q && !rd_ack;
    end else if (rd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this clock edge.
    if (reset) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      nwin_q    <= '0;
      p0_q      <= '0;
      m0_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      nwin_q    <= nwin_d;
      p0_q      <= p0_d;
      m0_q      <= m0_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign cnt_clear    = (state_q == S_CLEAR);
  assign cnt_en       = (state_q == S_SETTLE) || (state_q == S_INTEGRATE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: directed conversions covering the basic
// conversion, counter wrap, num_windows=0, continuous mode with overrun,
// stop and reset. A cycle-level reference model checks every output on each
// falling edge, and literal expectations pin the key results.
module tb_adc_conv_sequencer;

  localparam int CNT_W = 24;
  localparam int WIN_W = 8;
  localparam int SETTLE_WINDOWS = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cont = 1'b0;
  logic [WIN_W-1:0] num_windows = '0;
  logic             window_tick = 1'b0;
  logic [CNT_W-1:0] count_p = '0;
  logic [CNT_W-1:0] count_m = '0;
  logic             rd_ack = 1'b0;
  logic             cnt_clear, cnt_en, busy, result_valid, overrun;
  logic [CNT_W:0]   result;
  logic [2:0]       state_dbg;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  adc_conv_sequencer #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_WINDOWS(SETTLE_WINDOWS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cont(cont),
    .num_windows(num_windows), .window_tick(window_tick),
    .count_p(count_p), .count_m(count_m),
    .cnt_clear(cnt_clear), .cnt_en(cnt_en), .busy(busy),
    .result(result), .result_valid(result_valid), .overrun(overrun),
    .rd_ack(rd_ack), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the conversion, ticks seen in that phase,
  // baselines and the published result as plain integers.
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_SETTLE = 2, PH_INTEG = 3,
                 PH_COMPUTE = 4;
  int phase = PH_IDLE;
  int ticks = 0;
  int target = 1;
  int base_p = 0, base_m = 0;
  int exp_res = 0;
  bit exp_valid = 1'b0;
  bit exp_ovr = 1'b0;

  always @(posedge clk) begin
    bit produced;
    int dpi, dmi;
    produced = 1'b0;
    if (reset) begin
      phase = PH_IDLE; ticks = 0; exp_res = 0; exp_valid = 0; exp_ovr = 0;
      base_p = 0; base_m = 0;
    end else begin
      if (phase == PH_IDLE) begin
        if (start) begin
          target = (num_windows == 0) ? 1 : int'(num_windows);
          phase = PH_CLEAR;
        end
      end else if (stop) begin
        phase = PH_IDLE;
      end else if (phase == PH_CLEAR) begin
        phase = PH_SETTLE; ticks = 0;
      end else if (phase == PH_SETTLE) begin
        if (window_tick) begin
          ticks++;
          if (ticks == SETTLE_WINDOWS) begin
            base_p = int'(count_p); base_m = int'(count_m);
            ticks = 0; phase = PH_INTEG;
          end
        end
      end else if (phase == PH_INTEG) begin
        if (window_tick) begin
          ticks++;
          if (ticks == target) begin
            dpi = int'(count_p) - base_p;
            if (dpi < 0) dpi += (1 << CNT_W);
            dmi = int'(count_m) - base_m;
            if (dmi < 0) dmi += (1 << CNT_W);
            exp_res = dpi - dmi;
            produced = 1'b1;
            phase = PH_COMPUTE;
          end
        end
      end else begin
        phase = cont ? PH_CLEAR : PH_IDLE;
      end
      if (produced) begin
        exp_ovr = exp_valid && !rd_ack;
        exp_valid = 1'b1;
      end else if (rd_ack && exp_valid) begin
        exp_valid = 1'b0; exp_ovr = 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic [CNT_W:0] er;
    if (cmp_en) begin
      er = (CNT_W+1)'(exp_res);
      check("m_state_dbg", 32'(state_dbg), 32'(phase));
      check("m_cnt_clear", 32'(cnt_clear), 32'(phase == PH_CLEAR));
      check("m_cnt_en", 32'(cnt_en), 32'(phase == PH_SETTLE || phase == PH_INTEG));
      check("m_busy", 32'(busy), 32'(phase != PH_IDLE));
      check("m_valid", 32'(result_valid), 32'(exp_valid));
      check("m_overrun", 32'(overrun), 32'(exp_ovr));
      check("m_result", 32'(result), 32'(er));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic tick(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] m);
    count_p = p; count_m = m; window_tick = 1'b1; cyc(); window_tick = 1'b0;
  endtask

  task automatic ack();
    rd_ack = 1'b1; cyc(); rd_ack = 1'b0;
  endtask

  initial begin
    idle(2);
    cmp_en = 1'b1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    reset = 1'b0;
    idle(1);

    // Basic conversion: 4 windows, +3000.
    num_windows = 8'd4;
    pulse_start();
    check("basic_clear", 32'(cnt_clear), 32'd1);
    check("basic_clear_en", 32'(cnt_en), 32'd0);
    cyc();
    check("basic_clear_once", 32'(cnt_clear), 32'd0);
    check("basic_settle_en", 32'(cnt_en), 32'd1);
    tick(24'd1000, 24'd400);
    idle(2);
    for (int k = 1; k <= 3; k++) begin
      tick(24'(1000 + k * 1000), 24'(400 + k * 200));
      idle(2);
    end
    tick(24'd5000, 24'd1400);
    check("basic_result", 32'(result), 32'd3000);
    check("basic_valid", 32'(result_valid), 32'd1);
    cyc();
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_state", 32'(state_dbg), 32'd0);

    // Counter wrap: dp=32, dm=100 -> -68.
    ack();
    check("ack_valid", 32'(result_valid), 32'd0);
    num_windows = 8'd1;
    pulse_start(); cyc();
    tick(24'hFFFFF0, 24'h000000); idle(1);
    tick(24'h000010, 24'h000064);
    check("wrap_result", 32'(result), 32'h1FFFFBC);
    idle(2);

    // num_windows=0, tick in IDLE, start while busy.
    ack();
    tick(24'd7, 24'd7);
    check("idle_tick", 32'(state_dbg), 32'd0);
    num_windows = 8'd0;
    pulse_start(); cyc();
    pulse_start();
    check("busy_start", 32'(state_dbg), 32'd2);
    tick(24'd100, 24'd50); idle(1);
    tick(24'd300, 24'd70);
    check("nw0_state", 32'(state_dbg), 32'd4);
    check("nw0_result", 32'(result), 32'd180);
    idle(2);

    // Continuous mode with overrun, then coincident ack.
    ack();
    cont = 1'b1; num_windows = 8'd1;
    pulse_start(); cyc();
    tick(24'd0, 24'd0); idle(1);
    tick(24'd10, 24'd3);
    check("cont_r1", 32'(result), 32'd7);
    cyc(); cyc();
    tick(24'd20, 24'd3); idle(1);
    tick(24'd50, 24'd13);
    check("cont_r2", 32'(result), 32'd20);
    check("cont_ovr", 32'(overrun), 32'd1);
    ack();
    check("ovr_ack_valid", 32'(result_valid), 32'd0);
    check("ovr_ack_ovr", 32'(overrun), 32'd0);
    cyc();
    tick(24'd0, 24'd0); idle(1);
    tick(24'd9, 24'd1);
    check("cont_r3", 32'(result), 32'd8);
    cyc();
    cont = 1'b0;
    cyc();
    tick(24'd0, 24'd0); idle(1);
    rd_ack = 1'b1;
    tick(24'd40, 24'd10);
    rd_ack = 1'b0;
    check("coinc_result", 32'(result), 32'd30);
    check("coinc_valid", 32'(result_valid), 32'd1);
    check("coinc_ovr", 32'(overrun), 32'd0);
    cyc();
    check("cont_end_state", 32'(state_dbg), 32'd0);

    // Stop on the final integrating tick.
    num_windows = 8'd2;
    pulse_start(); cyc();
    tick(24'd0, 24'd0); idle(1);
    tick(24'd5, 24'd0); idle(1);
    stop = 1'b1;
    tick(24'd99, 24'd0);
    stop = 1'b0;
    check("stop_state", 32'(state_dbg), 32'd0);
    check("stop_en", 32'(cnt_en), 32'd0);
    check("stop_result", 32'(result), 32'd30);
    check("stop_valid", 32'(result_valid), 32'd1);
    idle(2);

    // Reset in INTEGRATE with a result pending, then a normal conversion.
    num_windows = 8'd1;
    pulse_start(); cyc();
    tick(24'd0, 24'd0);
    check("pre_rst_state", 32'(state_dbg), 32'd3);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_en", 32'(cnt_en), 32'd0);
    pulse_start(); cyc();
    tick(24'd100, 24'd100); idle(1);
    tick(24'd150, 24'd110);
    check("post_rst_result", 32'(result), 32'd40);
    check("post_rst_valid", 32'(result_valid), 32'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
